modbus_rtu_master_req: RTL

- Upstream request generator for the Modbus RTU slave. It drives that slave's rs485_rx line and is used as a test master and as a bring-up initiator on the RS485 bus.
- Accepts one request (function 0x03, 0x04 or 0x06) as parallel fields. Computes the Modbus CRC-16 and serialises the 8-byte ADU as UART 8N1.
- Controls the RS485 driver enable with lead and lag guard times, then enforces the 3.5-character inter-frame gap before it reports done.

---
 rtl/modbus_rtu_master_req_pkg.sv | 45 ++++
 rtl/modbus_crc16_bit.sv | 32 +++
 rtl/modbus_rtu_master_req.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/modbus_rtu_master_req_pkg.sv
// Shared definitions for the Modbus RTU request generator: state encoding,
// CRC constants, frame geometry and the ADU byte selector.
package modbus_rtu_master_req_pkg;

    localparam logic [15:0] MB_CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] MB_CRC_POLY     = 16'hA001;
    localparam int unsigned MB_FRAME_BYTES  = 8;
    localparam int unsigned MB_PAYLOAD_BITS = 48;
    localparam int unsigned MB_GAP_BITS     = 39;
    localparam int unsigned MB_UART_BITS    = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_LEAD,
        ST_SEND,
        ST_LAG,
        ST_GAP
    } mb_state_t;

    typedef struct packed {
        logic [7:0]  dev_addr;
        logic [7:0]  func;
        logic [15:0] addr;
        logic [15:0] data;
    } mb_req_t;

    // ADU byte in line order; the CRC goes low byte first.
    function automatic logic [7:0] mb_adu_byte(input mb_req_t req, input logic [15:0] crc,
                                               input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = req.dev_addr;
            3'd1:    b = req.func;
            3'd2:    b = req.addr[15:8];
            3'd3:    b = req.addr[7:0];
            3'd4:    b = req.data[15:8];
            3'd5:    b = req.data[7:0];
            3'd6:    b = crc[7:0];
            default: b = crc[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/modbus_crc16_bit.sv
// Bit-serial Modbus CRC-16 (reflected 0xA001), one data bit per enabled cycle.
module modbus_crc16_bit
    import modbus_rtu_master_req_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_bit,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc >> 1;
        if (crc[0] ^ data_bit) begin
            crc_next = crc_next ^ MB_CRC_POLY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= MB_CRC_INIT;
        end else if (clear) begin
            crc <= MB_CRC_INIT;
        end else if (enable) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/modbus_rtu_master_req.sv
// Modbus RTU request generator: latches one request, computes its CRC and
// sends the 8-byte ADU as UART 8N1 with RS485 driver-enable guard times.
module modbus_rtu_master_req
    import modbus_rtu_master_req_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned OE_LEAD_BITS = 1,
    parameter int unsigned OE_LAG_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_start,
    input  logic [7:0]  req_dev_addr,
    input  logic [7:0]  req_func,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic        req_busy,
    output logic        req_done,
    output logic        rs485_tx,
    output logic        rs485_oe
);

    localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned LEAD_CYC = OE_LEAD_BITS * BIT_CNT;
    localparam int unsigned LAG_CYC  = OE_LAG_BITS * BIT_CNT;
    localparam int unsigned GAP_CYC  = MB_GAP_BITS * BIT_CNT;
    localparam int unsigned MAX_A    = (GAP_CYC > LEAD_CYC) ? GAP_CYC : LEAD_CYC;
    localparam int unsigned CNT_MAX  = (MAX_A > LAG_CYC) ? MAX_A : LAG_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    mb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       byte_q, byte_d;
    logic [3:0]       bit_q, bit_d;
    mb_req_t          req_q, req_d;
    logic             tx_d, oe_d, busy_d, done_d;
    logic [15:0]      crc;
    logic [7:0]       crc_byte;
    logic [7:0]       tx_byte;
    logic             accept;

    assign accept   = (state_q == ST_IDLE) && req_start;
    // During CRC the cycle counter doubles as the payload bit pointer.
    assign crc_byte = mb_adu_byte(req_q, crc, cnt_q[5:3]);

    modbus_crc16_bit u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .enable   (state_q == ST_CRC),
        .data_bit (crc_byte[cnt_q[2:0]]),
        .crc      (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            req_q    <= '0;
            rs485_tx <= 1'b1;
            rs485_oe <= 1'b0;
            req_busy <= 1'b0;
            req_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            req_q    <= req_d;
            rs485_tx <= tx_d;
            rs485_oe <= oe_d;
            req_busy <= busy_d;
            req_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        byte_d  = byte_q;
        bit_d   = bit_q;
        req_d   = req_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        tx_byte = 8'h00;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                byte_d = '0;
                bit_d  = '0;
                if (req_start) begin
                    state_d        = ST_CRC;
                    req_d.dev_addr = req_dev_addr;
                    req_d.func     = req_func;
                    req_d.addr     = req_addr;
                    req_d.data     = req_data;
                end
            end
            ST_CRC: begin
                if (cnt_q == CNT_W'(MB_PAYLOAD_BITS - 1)) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                end
            end
            ST_LEAD: begin
                if (cnt_q == CNT_W'(LEAD_CYC - 1)) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (cnt_q == CNT_W'(BIT_CNT - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'(MB_UART_BITS - 1)) begin
                        bit_d = '0;
                        if (byte_q == 3'(MB_FRAME_BYTES - 1)) begin
                            state_d = ST_LAG;
                        end else begin
                            byte_d = byte_q + 3'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_LAG: begin
                if (cnt_q == CNT_W'(LAG_CYC - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registers line up with it.
        tx_byte = mb_adu_byte(req_d, crc, byte_d);
        if (state_d == ST_SEND) begin
            if (bit_d == 4'd0) begin
                tx_d = 1'b0;
            end else if (bit_d == 4'(MB_UART_BITS - 1)) begin
                tx_d = 1'b1;
            end else begin
                tx_d = tx_byte[3'(bit_d - 4'd1)];
            end
        end
        oe_d   = (state_d == ST_LEAD) || (state_d == ST_SEND) || (state_d == ST_LAG);
        busy_d = (state_d != ST_IDLE);
    end

endmodule
